lpc_host: RTL and testbench
===========================

// Module: lpc_host
// PURPOSE
//  LPC bus initiator: turns single-byte I/O read/write requests into LPC ISA I/O cycles
//  (START, CTDIR, ADDR, DATA, TAR, SYNC) and returns read data/status. Drives the LPC side of
//  our UART device (ports 0x3F8-0x3FF) from on-chip logic, e.g. a debug bridge, and serves as
//  the synthesizable host model in benches.
// PARAMETERS
//  SYNC_TIMEOUT  8  cycles of no-SYNC (AD=1111) before abort; counter 8 bits, valid range 2..255
//  WR_HI_FIRST   1  write data nibble order: 1 = [7:4] then [3:0] (our UART device); 0 = LPC-spec low first
//  ABORT_LEN     4  cycles lpc_frame held low on abort (>=4)
// PORTS
//  lpc_clk     in   1   LPC clock; all logic on rising edge
//  lpc_rst     in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   1 only in IDLE; request accepted when req_valid & req_ready
//  req_write   in   1   1 = IOWR, 0 = IORD
//  req_addr    in   16  I/O port address
//  req_wdata   in   8   write data
//  rsp_valid   out  1   1-cycle pulse: cycle finished
//  rsp_rdata   out  8   read data (8'hFF on write, error, abort)
//  rsp_err     out  1   qualified by rsp_valid: error SYNC or timeout abort
//  lpc_ad_out  out  4   LAD drive value
//  lpc_ad_oe   out  1   LAD output enable (top level builds tristate)
//  lpc_ad_in   in   4   LAD sampled value
//  lpc_frame   out  1   LFRAME#, active low
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=4'hF, rsp_valid=0,
//   rsp_err=0, rsp_rdata=8'hFF, timeout counter=0. Request in flight is dropped, no rsp.
//  All LPC outputs registered. Request fields latched at accept; req_valid in other states ignored.
//  States, one lpc_clk each unless noted (oe=1 unless stated):
//   IDLE    frame=1, oe=0. Accept -> START.
//   START   frame=0, AD=0000.
//   CTDIR   frame=1, AD=0010 write / 0000 read.
//   ADDR0-3 AD=addr[15:12],[11:8],[7:4],[3:0].
//   WDATA0-1 (write only) nibble order per WR_HI_FIRST.
//   TAR     AD=1111, oe=1 (drives bus high one cycle).
//   SYNC    oe=0; sample lpc_ad_in every cycle (multi-cycle):
//     0000 ready -> RDATA0 (read) / TARIN0 (write).
//     0101 short wait: stay, timeout counter counts. 0110 long wait: stay, counter cleared, no timeout.
//     1111 no response: stay, counter counts; counter == SYNC_TIMEOUT -> ABORT.
//     1010 error: rsp_err latched; continue as ready (read still consumes data phase).
//     any other value: treated as error -> ABORT.
//   RDATA0/1 oe=0; sample lpc_ad_in -> rsp_rdata[3:0] then [7:4] (always low first).
//   TARIN0/1 oe=0, peripheral turnaround; after TARIN1 -> IDLE with rsp_valid=1.
//   ABORT   frame=0, oe=1, AD=1111 for ABORT_LEN cycles, then one frame=1 cycle, -> IDLE,
//     rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF.
//  req_ready is 0 in the cycle rsp_valid pulses; next accept earliest one cycle later.
//  Latency (accept edge to rsp_valid), SYNC ready on k-th SYNC cycle (k>=1):
//   write = 10 + k + 2 cycles; read = 8 + k + 2 + 2 cycles. 1-cycle-TAR peripherals give 1111
//   on first SYNC cycle, treated as no-response (k=2) - no special case needed.
//  rsp_err cleared at each accept.
// TESTING
//  Write 0x03F8 data 0x5A, model SYNC 0000 on 2nd SYNC cycle -> AD sequence 0,2,0,3,F,8,5,A,F
//   with frame low only on START; rsp_valid 14 cycles after accept, rsp_err=0, rsp_rdata=FF.
//  Read 0x03FD, model SYNC 0000 then nibbles 0,6 -> rsp_rdata=0x60, rsp_err=0; WR_HI_FIRST=0 build
//   write 0x5A -> data nibbles A,5.
//  Read with 20 cycles SYNC 0110 then 0000, data F,0 -> no abort, rsp_rdata=0x0F, rsp_err=0.
//  No peripheral (lpc_ad_in=1111) -> after 8 SYNC cycles frame low exactly 4 cycles with AD=1111,
//   then rsp_valid with rsp_err=1, rsp_rdata=FF; a following read to 0x03F8 completes normally.
//  SYNC 1010 on read with data 3,C -> rsp_err=1, full data phase + TARIN consumed; SYNC 0011 -> abort.
//  Assert lpc_rst during ADDR2 -> same cycle frame=1, oe=0, no rsp_valid; req_ready=1 after release;
//   req_valid held during busy cycles never causes a second cycle.

Source files
------------

// File: rtl/lpc_host_if.sv
// Request/response handshake plus LPC bus signals for lpc_host.
// master: host side (lpc_host); slave: requester and peripheral side.
interface lpc_host_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;
  logic        lpc_frame;

  modport master (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    input  lpc_ad_in,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output lpc_ad_out, lpc_ad_oe,
    output lpc_frame
  );

  modport slave (
    output req_valid, req_write,
    output req_addr, req_wdata,
    output lpc_ad_in,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  lpc_ad_out, lpc_ad_oe,
    input  lpc_frame
  );
endinterface

// File: rtl/lpc_host.sv
// LPC I/O cycle initiator: one byte IORD/IOWR per request, rsp on finish.
// Ports: lpc_clk, lpc_rst (async, high), bus (lpc_host_if.master).
module lpc_host #(
  parameter int SYNC_TIMEOUT = 8,
  parameter bit WR_HI_FIRST  = 1'b1,
  parameter int ABORT_LEN    = 4
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  lpc_host_if.master bus
);

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_CTDIR,
    S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
    S_WDATA0, S_WDATA1, S_TAR, S_SYNC,
    S_RDATA0, S_RDATA1,
    S_TARIN0, S_TARIN1,
    S_ABORT, S_ABEND
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(SYNC_TIMEOUT - 1);
  localparam logic [7:0] AB_LAST = 8'(ABORT_LEN - 1);

  state_t      state;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  cnt;

  logic [3:0]  wd_first;
  logic [3:0]  wd_second;

  logic sync_ok;
  logic sync_err;
  logic sync_wait;
  logic sync_long;
  logic sync_bad;
  logic timeout;

  assign wd_first  = WR_HI_FIRST ? wdata[7:4] : wdata[3:0];
  assign wd_second = WR_HI_FIRST ? wdata[3:0] : wdata[7:4];

  always_comb begin
    sync_ok   = 1'b0;
    sync_err  = 1'b0;
    sync_wait = 1'b0;
    sync_long = 1'b0;
    sync_bad  = 1'b0;
    unique case (bus.lpc_ad_in)
      4'b0000: sync_ok   = 1'b1;
      4'b1010: sync_err  = 1'b1;
      4'b0101,
      4'b1111: sync_wait = 1'b1;
      4'b0110: sync_long = 1'b1;
      default: sync_bad  = 1'b1;
    endcase
  end

  // Short waits and no-response both run the same counter.
  assign timeout = sync_wait && (cnt == TO_LAST);

  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      state          <= S_IDLE;
      wr             <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      rdata          <= 8'hFF;
      cnt            <= '0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_rdata  <= 8'hFF;
      bus.lpc_frame  <= 1'b1;
      bus.lpc_ad_oe  <= 1'b0;
      bus.lpc_ad_out <= 4'hF;
    end else begin
      bus.rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            wr             <= bus.req_write;
            addr           <= bus.req_addr;
            wdata          <= bus.req_wdata;
            cnt            <= '0;
            bus.rsp_err    <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.lpc_frame  <= 1'b0;
            bus.lpc_ad_oe  <= 1'b1;
            bus.lpc_ad_out <= 4'h0;
            state          <= S_START;
          end else begin
            // Re-arms one cycle after the rsp pulse.
            bus.req_ready <= 1'b1;
          end
        end
        S_START: begin
          bus.lpc_frame  <= 1'b1;
          bus.lpc_ad_out <= wr ? 4'h2 : 4'h0;
          state          <= S_CTDIR;
        end
        S_CTDIR: begin
          bus.lpc_ad_out <= addr[15:12];
          state          <= S_ADDR0;
        end
        S_ADDR0: begin
          bus.lpc_ad_out <= addr[11:8];
          state          <= S_ADDR1;
        end
        S_ADDR1: begin
          bus.lpc_ad_out <= addr[7:4];
          state          <= S_ADDR2;
        end
        S_ADDR2: begin
          bus.lpc_ad_out <= addr[3:0];
          state          <= S_ADDR3;
        end
        S_ADDR3: begin
          if (wr) begin
            bus.lpc_ad_out <= wd_first;
            state          <= S_WDATA0;
          end else begin
            bus.lpc_ad_out <= 4'hF;
            state          <= S_TAR;
          end
        end
        S_WDATA0: begin
          bus.lpc_ad_out <= wd_second;
          state          <= S_WDATA1;
        end
        S_WDATA1: begin
          bus.lpc_ad_out <= 4'hF;
          state          <= S_TAR;
        end
        S_TAR: begin
          bus.lpc_ad_oe <= 1'b0;
          state         <= S_SYNC;
        end
        S_SYNC: begin
          if (sync_ok || sync_err) begin
            if (sync_err) bus.rsp_err <= 1'b1;
            state <= wr ? S_TARIN0 : S_RDATA0;
          end else if (sync_bad || timeout) begin
            bus.rsp_err    <= 1'b1;
            bus.lpc_frame  <= 1'b0;
            bus.lpc_ad_oe  <= 1'b1;
            bus.lpc_ad_out <= 4'hF;
            cnt            <= '0;
            state          <= S_ABORT;
          end else if (sync_wait) begin
            cnt <= cnt + 8'd1;
          end else if (sync_long) begin
            cnt <= '0;
          end
        end
        S_RDATA0: begin
          rdata[3:0] <= bus.lpc_ad_in;
          state      <= S_RDATA1;
        end
        S_RDATA1: begin
          rdata[7:4] <= bus.lpc_ad_in;
          state      <= S_TARIN0;
        end
        S_TARIN0: state <= S_TARIN1;
        S_TARIN1: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= (wr || bus.rsp_err) ? 8'hFF : rdata;
          state         <= S_IDLE;
        end
        S_ABORT: begin
          if (cnt == AB_LAST) begin
            bus.lpc_frame <= 1'b1;
            state         <= S_ABEND;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ABEND: begin
          bus.lpc_ad_oe <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= 8'hFF;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: vector table, reset corner, WR_HI_FIRST=0 build,
// and random transactions against a cycle-level bus model.
module tb_lpc_host;

  localparam int TO  = 8;
  localparam int ABL = 4;
  localparam int LIM = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lpc_host_if bus ();
  lpc_host_if bus2 ();

  lpc_host dut (
    .lpc_clk (clk),
    .lpc_rst (rst),
    .bus     (bus)
  );

  lpc_host #(.WR_HI_FIRST(1'b0)) dut2 (
    .lpc_clk (clk),
    .lpc_rst (rst),
    .bus     (bus2)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] sq[$];

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [3:0]  fill;
    int          nfill;
    bit          has_last;
    logic [3:0]  last;
    logic [3:0]  lo;
    logic [3:0]  hi;
    bit          hold;
    bit          e_err;
    logic [7:0]  e_rd;
    int          e_lat;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mkv(
    bit w, logic [15:0] a, logic [7:0] wd,
    logic [3:0] fill, int nfill,
    bit has_last, logic [3:0] last,
    logic [3:0] lo, logic [3:0] hi, bit hold,
    bit e_err, logic [7:0] e_rd, int e_lat);
    vec_t v;
    v.w = w; v.a = a; v.wd = wd;
    v.fill = fill; v.nfill = nfill;
    v.has_last = has_last; v.last = last;
    v.lo = lo; v.hi = hi; v.hold = hold;
    v.e_err = e_err; v.e_rd = e_rd; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the SYNC stream (F once the stream runs out).
  function automatic void model(output int k,
                                output bit ab,
                                output bit er);
    int c;
    logic [3:0] s;
    c = 0; ab = 1'b0; er = 1'b0; k = 0;
    for (int i = 0; i < 256; i++) begin
      s = (i < sq.size()) ? sq[i] : 4'hF;
      k = i + 1;
      if (s == 4'h0) return;
      if (s == 4'hA) begin er = 1'b1; return; end
      if (s == 4'h5 || s == 4'hF) begin
        c++;
        if (c == TO) begin ab = 1'b1; er = 1'b1; return; end
      end else if (s == 4'h6) begin
        c = 0;
      end else begin
        ab = 1'b1; er = 1'b1; return;
      end
    end
  endfunction

  function automatic logic [3:0] hdr(bit w, logic [15:0] a,
                                     logic [7:0] wd, int i);
    logic [15:0] t;
    if (i == 0) return 4'h0;
    if (i == 1) return w ? 4'h2 : 4'h0;
    if (i >= 2 && i <= 5) begin
      t = a >> (4 * (5 - i));
      return t[3:0];
    end
    if (w && i == 6) return wd[7:4];
    if (w && i == 7) return wd[3:0];
    return 4'hF;
  endfunction

  function automatic logic [3:0] drv(int n, bit w, int k, bit ab,
                                     logic [3:0] lo, logic [3:0] hi);
    int pre;
    int i;
    pre = w ? 10 : 8;
    if (n >= pre && n < pre + k) begin
      i = n - pre;
      return (i < sq.size()) ? sq[i] : 4'hF;
    end
    if (!ab && !w && n == pre + k) return lo;
    if (!ab && !w && n == pre + k + 1) return hi;
    return 4'hF;
  endfunction

  task automatic do_txn(input string nm, input bit w,
                        input logic [15:0] a, input logic [7:0] wd,
                        input logic [3:0] lo, input logic [3:0] hi,
                        input bit hold, input bit use_exp,
                        input bit x_err, input logic [7:0] x_rd,
                        input int x_lat);
    int k, pre, elat, lat_act, bad, first_bad, g;
    bit ab, er, ok, eerr;
    logic [7:0] erd;
    model(k, ab, er);
    pre  = w ? 10 : 8;
    elat = pre + k + (ab ? ABL + 1 : (w ? 2 : 4));
    eerr = er;
    erd  = (w || er) ? 8'hFF : {hi, lo};
    if (use_exp) begin
      elat = x_lat; eerr = x_err; erd = x_rd;
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.lpc_ad_in = 4'hF;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk({nm, "_accept"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    lat_act = -1; bad = 0; first_bad = -1;
    for (int n = 1; n <= LIM; n++) begin
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        lat_act = n;
        break;
      end
      if (n < elat) begin
        if (n < pre)
          ok = (bus.lpc_frame === (n != 1)) &&
               (bus.lpc_ad_oe === 1'b1) &&
               (bus.lpc_ad_out === hdr(w, a, wd, n - 1));
        else if (!ab || n < pre + k)
          ok = (bus.lpc_frame === 1'b1) && (bus.lpc_ad_oe === 1'b0);
        else if (n < pre + k + ABL)
          ok = (bus.lpc_frame === 1'b0) && (bus.lpc_ad_oe === 1'b1) &&
               (bus.lpc_ad_out === 4'hF);
        else
          ok = (bus.lpc_frame === 1'b1);
        if (bus.req_ready !== 1'b0) ok = 1'b0;
        if (!ok) begin
          bad++;
          if (first_bad < 0) first_bad = n;
        end
      end
      bus.lpc_ad_in = drv(n, w, k, ab, lo, hi);
    end
    bus.lpc_ad_in = 4'hF;
    bus.req_valid = 1'b0;
    chk({nm, "_lat"}, 32'(lat_act), 32'(elat));
    if (bad != 0)
      $display("  %s first bad bus cycle %0d", nm, first_bad);
    chk({nm, "_bus"}, 32'(bad), 32'd0);
    if (lat_act < 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    chk({nm, "_err"}, 32'(bus.rsp_err), 32'(eerr));
    chk({nm, "_rdata"}, 32'(bus.rsp_rdata), 32'(erd));
    chk({nm, "_rdy_rsp"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk({nm, "_rdy_nxt"}, 32'(bus.req_ready), 32'd1);
    chk({nm, "_frame_idle"}, 32'(bus.lpc_frame), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_rsp, n_flo, g, lat2;
    logic [3:0] d0, d1;
    logic [3:0] oth[11];
    int r, len;
    bit w, hold;

    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.lpc_ad_in = 4'hF;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0;
    bus2.req_addr = '0; bus2.req_wdata = '0;
    bus2.lpc_ad_in = 4'h0;

    tbl[0]  = mkv(1, 16'h03F8, 8'h5A, 4'hF, 1,  1, 4'h0, 4'h0, 4'h0, 0, 0, 8'hFF, 14);
    tbl[1]  = mkv(0, 16'h03FD, 8'h00, 4'hF, 0,  1, 4'h0, 4'h0, 4'h6, 1, 0, 8'h60, 13);
    tbl[2]  = mkv(0, 16'h03FD, 8'h00, 4'h6, 20, 1, 4'h0, 4'hF, 4'h0, 0, 0, 8'h0F, 33);
    tbl[3]  = mkv(0, 16'h03FD, 8'h00, 4'hF, 30, 0, 4'h0, 4'h0, 4'h0, 0, 1, 8'hFF, 21);
    tbl[4]  = mkv(0, 16'h03F8, 8'h00, 4'hF, 1,  1, 4'h0, 4'h5, 4'hA, 0, 0, 8'hA5, 14);
    tbl[5]  = mkv(0, 16'h03FC, 8'h00, 4'hF, 1,  1, 4'hA, 4'h3, 4'hC, 0, 1, 8'hFF, 14);
    tbl[6]  = mkv(0, 16'h03F9, 8'h00, 4'hF, 0,  1, 4'h3, 4'h0, 4'h0, 0, 1, 8'hFF, 14);
    tbl[7]  = mkv(1, 16'h0080, 8'hC3, 4'h5, 3,  1, 4'h0, 4'h0, 4'h0, 1, 0, 8'hFF, 16);
    tbl[8]  = mkv(1, 16'h03FB, 8'h81, 4'h5, 7,  1, 4'h0, 4'h0, 4'h0, 0, 0, 8'hFF, 20);
    tbl[9]  = mkv(1, 16'h03FB, 8'h81, 4'h5, 8,  1, 4'h0, 4'h0, 4'h0, 0, 1, 8'hFF, 23);
    tbl[10] = mkv(1, 16'h1234, 8'h00, 4'hF, 0,  1, 4'hA, 4'h0, 4'h0, 0, 1, 8'hFF, 13);
    tbl[11] = mkv(0, 16'hFFFF, 8'h00, 4'hF, 7,  1, 4'h0, 4'hF, 4'hF, 1, 0, 8'hFF, 20);

    oth = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8,
            4'h9, 4'hB, 4'hC, 4'hD, 4'hE};

    repeat (2) @(negedge clk);
    chk("rst_frame", 32'(bus.lpc_frame), 32'd1);
    chk("rst_oe", 32'(bus.lpc_ad_oe), 32'd0);
    chk("rst_ad", 32'(bus.lpc_ad_out), 32'hF);
    chk("rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'hFF);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      sq.delete();
      repeat (tbl[i].nfill) sq.push_back(tbl[i].fill);
      if (tbl[i].has_last) sq.push_back(tbl[i].last);
      do_txn($sformatf("v%0d", i), tbl[i].w, tbl[i].a, tbl[i].wd,
             tbl[i].lo, tbl[i].hi, tbl[i].hold, 1'b1,
             tbl[i].e_err, tbl[i].e_rd, tbl[i].e_lat);
    end

    // Reset mid-cycle (ADDR2) with req_valid held throughout.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h03F8;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    chk("pre_rst_oe", 32'(bus.lpc_ad_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_frame", 32'(bus.lpc_frame), 32'd1);
    chk("arst_oe", 32'(bus.lpc_ad_oe), 32'd0);
    chk("arst_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.req_ready), 32'd1);
    n_rsp = 0; n_flo = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_rsp++;
      if (bus.lpc_frame !== 1'b1) n_flo++;
    end
    chk("arst_no_rsp", 32'(n_rsp), 32'd0);
    chk("arst_no_frame", 32'(n_flo), 32'd0);

    // Low-nibble-first write build.
    @(negedge clk);
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b1;
    bus2.req_addr  = 16'h03F8;
    bus2.req_wdata = 8'h5A;
    g = 0;
    while (bus2.req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    d0 = 4'h0; d1 = 4'h0; lat2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus2.req_valid = 1'b0;
      if (n == 7) d0 = bus2.lpc_ad_out;
      if (n == 8) d1 = bus2.lpc_ad_out;
      if (bus2.rsp_valid === 1'b1) begin
        lat2 = n;
        break;
      end
    end
    chk("lofirst_d0", 32'(d0), 32'hA);
    chk("lofirst_d1", 32'(d1), 32'h5);
    chk("lofirst_lat", 32'(lat2), 32'd13);

    for (int t = 0; t < 40; t++) begin
      sq.delete();
      len = $urandom_range(0, 10);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 9);
        if (r <= 3)      sq.push_back(4'hF);
        else if (r <= 6) sq.push_back(4'h5);
        else if (r <= 8) sq.push_back(4'h6);
        else             sq.push_back(oth[$urandom_range(0, 10)]);
      end
      r = $urandom_range(0, 9);
      if (r <= 5)      sq.push_back(4'h0);
      else if (r <= 7) sq.push_back(4'hA);
      else if (r == 8) sq.push_back(oth[$urandom_range(0, 10)]);
      w    = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      do_txn($sformatf("r%0d", t), w, 16'($urandom),
             8'($urandom), 4'($urandom), 4'($urandom),
             hold, 1'b0, 1'b0, 8'h00, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
